regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between NUM_REQ writeback requesters (ALU, load unit, CSR/debug) using round-robin arbitration. One registered write stage drives the register file write enable, write address and write data. Writes to x0 are squashed. The block also counts cycles in which more than one requester was valid but only one could be granted.

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// The optional bypass outputs are enabled with the macro RF_WB_BYPASS_EN.
package regfile_wb_arbiter_pkg;

  localparam int RF_ADDR_W = 5;   // register address width
  localparam int DEF_WIDTH = 32;  // default register data width
  localparam int X0_ADDR   = 0;   // hard-wired zero register

  // Requester slots on the writeback port
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: scans from ptr upward (wrapping) and grants
// the first asserted request. Returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // Priority scan starting at the pointer; first hit wins
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (en && !any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register file write port between NUM_REQ
// writeback requesters, with one registered write stage, x0 squashing and a
// saturating contention counter.
// Optional macro RF_WB_BYPASS_EN adds two combinational read-bypass ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [WIDTH-1:0]          rf_wdata,
  output logic [CNT_W-1:0]          collide_cnt,
  input  logic                      collide_clr
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         byp_addr1,
  input  logic [ADDR_W-1:0]         byp_addr2,
  input  logic [WIDTH-1:0]          byp_data1,
  input  logic [WIDTH-1:0]          byp_data2,
  output logic [WIDTH-1:0]          byp_out1,
  output logic [WIDTH-1:0]          byp_out2
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [IDX_W-1:0]  ptr_next;
  logic              contend;

  // Grants are suppressed while stalled or held in reset
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (!stall && rst_n),
    .grant (req_ready),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign contend  = !stall && ($countones(req_valid) >= 2);

  // Write stage and pointer: capture the granted request, squash x0 writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= IDX_W'(REQ_ALU);
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (gnt_any) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      rr_ptr   <= ptr_next;
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
      rf_we    <= (sel_addr != ADDR_W'(X0_ADDR));
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Contention counter: clear wins over increment, saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collide_cnt <= '0;
    end else if (collide_clr) begin
      collide_cnt <= '0;
    end else if (contend && (collide_cnt != '1)) begin
      collide_cnt <= collide_cnt + CNT_W'(1);
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Forward the in-flight write to readers of the same non-zero register
  assign byp_out1 = (rf_we && (rf_waddr == byp_addr1) && (byp_addr1 != ADDR_W'(X0_ADDR)))
                    ? rf_wdata : byp_data1;
  assign byp_out2 = (rf_we && (rf_waddr == byp_addr2) && (byp_addr2 != ADDR_W'(X0_ADDR)))
                    ? rf_wdata : byp_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (two requesters, 3-bit collision
// counter so saturation is reachable). Bypass checks run when RF_WB_BYPASS_EN
// is defined.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      stall;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [WIDTH-1:0]          rf_wdata;
  logic [CNT_W-1:0]          collide_cnt;
  logic                      collide_clr;
`ifdef RF_WB_BYPASS_EN
  logic [ADDR_W-1:0]         byp_addr1, byp_addr2;
  logic [WIDTH-1:0]          byp_data1, byp_data2, byp_out1, byp_out2;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .collide_cnt (collide_cnt),
    .collide_clr (collide_clr)
`ifdef RF_WB_BYPASS_EN
    ,
    .byp_addr1   (byp_addr1),
    .byp_addr2   (byp_addr2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2),
    .byp_out1    (byp_out1),
    .byp_out2    (byp_out2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[r*ADDR_W +: ADDR_W] = a;
    req_data[r*WIDTH +: WIDTH]   = d;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [WIDTH-1:0] d);
    check({tag, "_we"},    64'(rf_we),    64'(we));
    check({tag, "_waddr"}, 64'(rf_waddr), 64'(a));
    check({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    collide_clr = 1'b0;
    req_valid   = 2'b11;
    req_addr    = '0;
    req_data    = '0;
`ifdef RF_WB_BYPASS_EN
    byp_addr1 = '0; byp_addr2 = '0; byp_data1 = '0; byp_data2 = '0;
`endif
    set_req(REQ_ALU, 5'd3, 32'h0000_0011);
    set_req(REQ_LSU, 5'd4, 32'h0000_0022);

    // Reset with both requesters valid
    step(); step();
    check("rst_ready", 64'(req_ready), 64'(2'b00));
    check_wr("rst", 1'b0, 5'd0, 32'd0);
    check("rst_cnt", 64'(collide_cnt), 64'd0);

    rst_n = 1'b1;
    #1;
    check("rel_ready0", 64'(req_ready), 64'(2'b01));
    step();
    check_wr("rel_wr0", 1'b1, 5'd3, 32'h11);
    check("rel_ready1", 64'(req_ready), 64'(2'b10));
    check("rel_cnt", 64'(collide_cnt), 64'd1);
    req_valid = 2'b10;
    step();
    check_wr("rel_wr1", 1'b1, 5'd4, 32'h22);
    check("rel_cnt_single", 64'(collide_cnt), 64'd1);
    req_valid   = 2'b00;
    collide_clr = 1'b1;
    step();
    collide_clr = 1'b0;
    check_wr("idle_hold", 1'b0, 5'd4, 32'h22);
    check("clr_cnt", 64'(collide_cnt), 64'd0);

    // Single requester 0
    req_valid = 2'b01;
    set_req(REQ_ALU, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("r0_ready", 64'(req_ready), 64'(2'b01));
    step();
    check_wr("r0_wr", 1'b1, 5'd5, 32'hDEAD_BEEF);

    // Requester 1 writing x0: accepted, squashed, pointer wraps to 0
    req_valid = 2'b10;
    set_req(REQ_LSU, 5'd0, 32'h0000_1234);
    #1;
    check("x0_ready", 64'(req_ready), 64'(2'b10));
    step();
    check("x0_we", 64'(rf_we), 64'd0);

    // Both valid for 6 cycles: alternating grants starting at requester 0
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      set_req(REQ_ALU, 5'd10, 32'h100 + i);
      set_req(REQ_LSU, 5'd11, 32'h200 + i);
      #1;
      check($sformatf("alt_ready%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      step();
      if (i % 2 == 0) check_wr($sformatf("alt_wr%0d", i), 1'b1, 5'd10, 32'h100 + i);
      else            check_wr($sformatf("alt_wr%0d", i), 1'b1, 5'd11, 32'h200 + i);
    end
    check("alt_cnt", 64'(collide_cnt), 64'd6);

    // Stall for 3 cycles with both valid: no grant, counter frozen
    stall = 1'b1;
    set_req(REQ_ALU, 5'd9, 32'h99);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_ready%0d", i), 64'(req_ready), 64'(2'b00));
      step();
      check($sformatf("stall_we%0d", i), 64'(rf_we), 64'd0);
    end
    check("stall_cnt", 64'(collide_cnt), 64'd6);
    stall = 1'b0;
    #1;
    check("unstall_ready", 64'(req_ready), 64'(2'b01));
    step();
    check_wr("unstall_wr", 1'b1, 5'd9, 32'h99);
    check("cnt_7", 64'(collide_cnt), 64'd7);

    // Saturation, then clear priority over increment
    step();
    check("cnt_sat", 64'(collide_cnt), 64'd7);
    collide_clr = 1'b1;
    step();
    collide_clr = 1'b0;
    check("cnt_clr_prio", 64'(collide_cnt), 64'd0);

`ifdef RF_WB_BYPASS_EN
    // Bypass of the in-flight write
    req_valid = 2'b00;
    step();
    req_valid = 2'b01;
    set_req(REQ_ALU, 5'd7, 32'hA5A5_A5A5);
    step();
    req_valid = 2'b00;
    byp_addr1 = 5'd7; byp_data1 = 32'd0;
    byp_addr2 = 5'd8; byp_data2 = 32'h0000_0BBB;
    #1;
    check("byp1_hit", 64'(byp_out1), 64'hA5A5_A5A5);
    check("byp2_miss", 64'(byp_out2), 64'h0BBB);
    byp_addr1 = 5'd0; byp_data1 = 32'h0000_0CCC;
    #1;
    check("byp1_x0", 64'(byp_out1), 64'h0CCC);
`endif

    // Reset mid-operation clears an in-flight write at once
    req_valid = 2'b01;
    set_req(REQ_ALU, 5'd12, 32'h0C0C_0C0C);
    step();
    check("mid_we_pre", 64'(rf_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check_wr("mid_rst", 1'b0, 5'd0, 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    step();
    check("mid_post_we", 64'(rf_we), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
